// File: rtl/tms9918_cpu_port.sv
// -----------------------------------------------------------------------------
// tms9918_cpu_port
// Host-side CPU interface of the TMS9918 VDP. Decodes MODE/read/write byte
// strobes into the 14-bit VRAM address latch, register writes, status reads
// and VRAM data accesses, and drives the VRAM CPU port including the
// read-ahead buffer with retry when the display fetch steals the read slot.
//
// Optional build macro: TMS9918_CPU_PORT_OVERRUN_EN
//   When defined, adds output 'overrun': a sticky flag set by any host strobe
//   that arrives while host_busy is high, cleared by a control (status) read.
// Bit numbering follows the original part: bit 0 is the MSB.
// -----------------------------------------------------------------------------
module tms9918_cpu_port (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        host_wr,
   input  logic        host_rd,
   input  logic        host_mode,
   input  logic [0:7]  host_wdata,
   output logic [0:7]  host_rdata,
   output logic        host_busy,
   input  logic [0:7]  status_in,
   output logic        status_rd,
   output logic        reg_wr,
   output logic [0:2]  reg_num,
   output logic [0:7]  reg_data,
   output logic        cpu_read,
   output logic        cpu_write,
   output logic [0:13] cpu_addr,
   output logic [0:7]  cpu_wdata,
   input  logic [0:7]  cpu_rdata,
   input  logic        cpu_read_ready
`ifdef TMS9918_CPU_PORT_OVERRUN_EN
   ,
   output logic        overrun
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [0:13] addr_q, addr_d;         // VRAM address pointer
   logic        flag_q, flag_d;         // 1 = next control write is the second byte
   logic [0:7]  latch_q, latch_d;       // first control byte
   logic [0:7]  buf_q, buf_d;           // read-ahead buffer
   logic [0:7]  rdata_q, rdata_d;
   logic        status_rd_q, status_rd_d;
   logic        reg_wr_q, reg_wr_d;
   logic [0:2]  reg_num_q, reg_num_d;
   logic [0:7]  reg_data_q, reg_data_d;
   logic        cpu_write_q, cpu_write_d;
   logic [0:13] wr_addr_q, wr_addr_d;   // address of the write in flight
   logic [0:7]  wdata_q, wdata_d;

   // Next-state decode: prefetch FSM plus host strobe handling (IDLE only).
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      flag_d      = flag_q;
      latch_d     = latch_q;
      buf_d       = buf_q;
      rdata_d     = rdata_q;
      status_rd_d = 1'b0;
      reg_wr_d    = 1'b0;
      reg_num_d   = reg_num_q;
      reg_data_d  = reg_data_q;
      cpu_write_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wdata_d     = wdata_q;

      case (state_q)
         ST_ISSUE: begin
            // Display fetch won the slot: keep requesting the same address.
            if (cpu_read_ready) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            buf_d   = cpu_rdata;
            addr_d  = addr_q + 14'd1;
            state_d = ST_IDLE;
         end
         default: begin
            // Host strobes are only honoured while idle; a write beats a read.
            if (host_wr && host_mode) begin
               if (!flag_q) begin
                  latch_d      = host_wdata;
                  addr_d[6:13] = host_wdata;
                  flag_d       = 1'b1;
               end else begin
                  flag_d = 1'b0;
                  if (host_wdata[0]) begin
                     reg_wr_d   = 1'b1;
                     reg_num_d  = host_wdata[5:7];
                     reg_data_d = latch_q;
                  end else begin
                     addr_d = {host_wdata[2:7], latch_q};
                     if (!host_wdata[1]) state_d = ST_ISSUE;
                  end
               end
            end else if (host_wr) begin
               cpu_write_d = 1'b1;
               wr_addr_d   = addr_q;
               wdata_d     = host_wdata;
               buf_d       = host_wdata;
               addr_d      = addr_q + 14'd1;
               flag_d      = 1'b0;
            end else if (host_rd && host_mode) begin
               rdata_d     = status_in;
               status_rd_d = 1'b1;
               flag_d      = 1'b0;
            end else if (host_rd) begin
               rdata_d = buf_q;
               flag_d  = 1'b0;
               state_d = ST_ISSUE;
            end
         end
      endcase
   end

   // State register with asynchronous reset; reset drops cpu_read at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         flag_q      <= 1'b0;
         latch_q     <= '0;
         buf_q       <= '0;
         rdata_q     <= '0;
         status_rd_q <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_num_q   <= '0;
         reg_data_q  <= '0;
         cpu_write_q <= 1'b0;
         wr_addr_q   <= '0;
         wdata_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         addr_q      <= addr_d;
         flag_q      <= flag_d;
         latch_q     <= latch_d;
         buf_q       <= buf_d;
         rdata_q     <= rdata_d;
         status_rd_q <= status_rd_d;
         reg_wr_q    <= reg_wr_d;
         reg_num_q   <= reg_num_d;
         reg_data_q  <= reg_data_d;
         cpu_write_q <= cpu_write_d;
         wr_addr_q   <= wr_addr_d;
         wdata_q     <= wdata_d;
      end
   end

`ifdef TMS9918_CPU_PORT_OVERRUN_EN
   logic overrun_q;

   // Sticky protocol-violation flag; a status read acknowledges it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
      end else if (host_busy && (host_wr || host_rd)) begin
         overrun_q <= 1'b1;
      end else if (!host_busy && host_rd && !host_wr && host_mode) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;
`endif

   // Writes and prefetches never overlap: a write only launches from IDLE.
   assign cpu_read   = (state_q == ST_ISSUE);
   assign cpu_write  = cpu_write_q;
   assign cpu_addr   = cpu_write_q ? wr_addr_q : addr_q;
   assign cpu_wdata  = wdata_q;
   assign host_busy  = (state_q != ST_IDLE);
   assign host_rdata = rdata_q;
   assign status_rd  = status_rd_q;
   assign reg_wr     = reg_wr_q;
   assign reg_num    = reg_num_q;
   assign reg_data   = reg_data_q;

endmodule
